// File: rtl/gate_check_pkg.sv
// gate_check_pkg
// Shared definitions for the basic-gate vector checker:
//   state_e     - checker FSM states (IDLE, APPLY, SETTLE, SAMPLE, DONE)
//   OBS_W       - width of the gate-block observation bus
//   NUM_VEC     - number of stimulus vectors in one sweep ({a,b} = 00..11)
//   IDX_*       - bit positions of each gate output inside obs
package gate_check_pkg;

  localparam int OBS_W   = 7;
  localparam int NUM_VEC = 4;

  localparam int IDX_AND   = 0;
  localparam int IDX_OR    = 1;
  localparam int IDX_NOT_A = 2;
  localparam int IDX_NAND  = 3;
  localparam int IDX_NOR   = 4;
  localparam int IDX_XOR   = 5;
  localparam int IDX_XNOR  = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/gate_golden_model.sv
// gate_golden_model
// Combinational reference for the 2-input gate block.
// Ports:
//   idx     in  2      vector index {a,b}
//   exp_obs out OBS_W  expected {xnor,xor,nor,nand,not_a,or,and}
module gate_golden_model
  import gate_check_pkg::*;
(
  input  logic [1:0]       idx,
  output logic [OBS_W-1:0] exp_obs
);

  always_comb begin
    exp_obs = '0;
    case (idx)
      2'd0:    exp_obs = 7'h5C;  // a=0 b=0
      2'd1:    exp_obs = 7'h2E;  // a=0 b=1
      2'd2:    exp_obs = 7'h2A;  // a=1 b=0
      default: exp_obs = 7'h43;  // a=1 b=1
    endcase
  end

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker
// Sweeps the four {a,b} vectors into a 2-input gate block, holds each one for
// SETTLE_CYCLES cycles, samples the 7 gate outputs and compares them with the
// golden model. Reports done/pass and a saturating count of failing vectors.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   ERR_W          width of the saturating error counter
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          level request for a full sweep
//   vec_a, vec_b   registered stimulus to the gate block
//   obs            gate outputs {xnor,xor,nor,nand,not_a,or,and}
//   busy           sweep in progress
//   done           sweep finished, held until next start or reset
//   pass           valid with done; 1 iff err_count == 0
//   err_count      failing vectors in this sweep (saturating)
//   cur_vec        index {a,b} of the vector being applied
//   dbg_state      current FSM state (state_e encoding)
// Optional (macro GATE_CHECK_FAIL_LOG_EN):
//   fail_valid, fail_vec, fail_obs - first failing vector of the sweep
//
// start/busy handshake: start is a level that is only looked at in IDLE or
// DONE; the cycle it is seen there the sweep is accepted and busy rises on the
// next edge. While busy is high start is ignored entirely. Holding start high
// across DONE restarts a new sweep one cycle after done rises.
module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             vec_a,
  output logic             vec_b,
  input  logic [OBS_W-1:0] obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef GATE_CHECK_FAIL_LOG_EN
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [OBS_W-1:0] fail_obs,
`endif
  output logic [1:0]       cur_vec,
  output logic [2:0]       dbg_state
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_vector_checker: SETTLE_CYCLES must be >= 1");
  end

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               vec_a_q, vec_a_d;
  logic               vec_b_q, vec_b_d;
  logic [1:0]         cur_vec_q, cur_vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [OBS_W-1:0]   exp_obs;
  logic               mismatch;
`ifdef GATE_CHECK_FAIL_LOG_EN
  logic               fail_valid_q, fail_valid_d;
  logic [1:0]         fail_vec_q, fail_vec_d;
  logic [OBS_W-1:0]   fail_obs_q, fail_obs_d;
`endif

  gate_golden_model u_golden (
    .idx     (idx_q),
    .exp_obs (exp_obs)
  );

  // One error per vector no matter how many output bits disagree.
  assign mismatch = (obs != exp_obs);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    vec_a_d   = vec_a_q;
    vec_b_d   = vec_b_q;
    cur_vec_d = cur_vec_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
`ifdef GATE_CHECK_FAIL_LOG_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_obs_d   = fail_obs_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = APPLY;
          idx_d   = 2'd0;
          err_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef GATE_CHECK_FAIL_LOG_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          fail_obs_d   = '0;
`endif
        end
      end
      APPLY: begin
        vec_a_d   = idx_q[1];
        vec_b_d   = idx_q[0];
        cur_vec_d = idx_q;
        cnt_d     = CNT_LOAD;
        state_d   = SETTLE;
      end
      SETTLE: begin
        // Loaded with S-1 so the FSM spends exactly S cycles here.
        if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + 1'b1;
        end
`ifdef GATE_CHECK_FAIL_LOG_EN
        if (mismatch && !fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_vec_d   = idx_q;
          fail_obs_d   = obs;
        end
`endif
        if (idx_q == 2'(NUM_VEC - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses the count including this last vector's result.
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      vec_a_q   <= 1'b0;
      vec_b_q   <= 1'b0;
      cur_vec_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef GATE_CHECK_FAIL_LOG_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_obs_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      vec_a_q   <= vec_a_d;
      vec_b_q   <= vec_b_d;
      cur_vec_q <= cur_vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
`ifdef GATE_CHECK_FAIL_LOG_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_obs_q   <= fail_obs_d;
`endif
    end
  end

  assign vec_a     = vec_a_q;
  assign vec_b     = vec_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign cur_vec   = cur_vec_q;
  assign dbg_state = state_q;
`ifdef GATE_CHECK_FAIL_LOG_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_obs   = fail_obs_q;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker
// Two checkers share clock and reset: dut0 (SETTLE_CYCLES=4, ERR_W=4) and
// dut1 (SETTLE_CYCLES=1, ERR_W=1). Each is wired to a behavioural gate block
// whose outputs pass through a fault mux (per-vector XOR mask, forced-zero mask).
module tb_gate_vector_checker;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;

  logic       vec_a0, vec_b0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [1:0] cur0;
  logic [2:0] dbg0;
  logic [6:0] obs0;

  logic       vec_a1, vec_b1, busy1, done1, pass1;
  logic [0:0] err1;
  logic [1:0] cur1;
  logic [2:0] dbg1;
  logic [6:0] obs1;

`ifdef GATE_CHECK_FAIL_LOG_EN
  logic       fv0, fv1;
  logic [1:0] fvec0, fvec1;
  logic [6:0] fobs0, fobs1;
`endif

  // fault mux controls
  logic [6:0] xm0 [4];
  logic [6:0] xm1 [4];
  logic [6:0] clr0, clr1;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  // Behavioural gate block: {xnor,xor,nor,nand,not_a,or,and}
  function automatic logic [6:0] gate_fn(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  always_comb obs0 = (gate_fn(vec_a0, vec_b0) ^ xm0[{vec_a0, vec_b0}]) & ~clr0;
  always_comb obs1 = (gate_fn(vec_a1, vec_b1) ^ xm1[{vec_a1, vec_b1}]) & ~clr1;

  gate_vector_checker #(.SETTLE_CYCLES(4), .ERR_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_a(vec_a0), .vec_b(vec_b0),
    .obs(obs0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
`ifdef GATE_CHECK_FAIL_LOG_EN
    .fail_valid(fv0), .fail_vec(fvec0), .fail_obs(fobs0),
`endif
    .cur_vec(cur0), .dbg_state(dbg0)
  );

  gate_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_a(vec_a1), .vec_b(vec_b1),
    .obs(obs1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
`ifdef GATE_CHECK_FAIL_LOG_EN
    .fail_valid(fv1), .fail_vec(fvec1), .fail_obs(fobs1),
`endif
    .cur_vec(cur1), .dbg_state(dbg1)
  );

  task automatic snap(input int sel, output logic d, output logic bz, output logic p,
                      output logic [3:0] e, output logic [1:0] cv, output logic [1:0] v,
                      output logic fv, output logic [1:0] fvec, output logic [6:0] fobs);
    d = sel ? done1 : done0;
    bz = sel ? busy1 : busy0;
    p = sel ? pass1 : pass0;
    e = sel ? {3'b000, err1} : err0;
    cv = sel ? cur1 : cur0;
    v = sel ? {vec_a1, vec_b1} : {vec_a0, vec_b0};
`ifdef GATE_CHECK_FAIL_LOG_EN
    fv = sel ? fv1 : fv0;
    fvec = sel ? fvec1 : fvec0;
    fobs = sel ? fobs1 : fobs0;
`else
    fv = 1'b0;
    fvec = 2'b00;
    fobs = 7'h00;
`endif
  endtask

  task automatic set_start(input int sel, input logic val);
    if (sel == 1) start1 = val;
    else start0 = val;
  endtask

  // Runs one sweep from start acceptance to done. Returns at posedge+1 of the done edge.
  task automatic run_sweep(input int sel, input int s, input bit hold_start, input string name);
    int per, last, emax, exp_err, exp_fi;
    logic [6:0] g, eff, exp_fobs;
    logic d, bz, p, fv;
    logic [3:0] e;
    logic [1:0] cv, v, fvec, ev;
    logic [6:0] fobs;
    per = s + 2;
    last = 4 * per;
    emax = (sel == 1) ? 1 : 15;
    exp_err = 0;
    exp_fi = -1;
    exp_fobs = 7'h00;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      g = gate_fn(i[1], i[0]);
      eff = sel ? ((g ^ xm1[i]) & ~clr1) : ((g ^ xm0[i]) & ~clr0);
      if (eff != g) begin
        if (exp_err < emax) exp_err++;
        if (exp_fi < 0) begin
          exp_fi = i;
          exp_fobs = eff;
        end
      end
      exp_q.push_back(2'(i));
    end
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    if (!hold_start) set_start(sel, 1'b0);
    snap(sel, d, bz, p, e, cv, v, fv, fvec, fobs);
    total++;
    if (bz !== 1'b1 || d !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", name, bz, d);
    end
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      #1;
      snap(sel, d, bz, p, e, cv, v, fv, fvec, fobs);
      if (n % per == 1) begin
        ev = exp_q.pop_front();
        total++;
        if (cv !== ev || v !== ev) begin
          bad++;
          $display("FAIL %s vec edge %0d: cur_vec=%b vec=%b want %b", name, n, cv, v, ev);
        end
      end
      if (n < last) begin
        total++;
        if (d !== 1'b0 || bz !== 1'b1) begin
          bad++;
          $display("FAIL %s busy edge %0d: done=%b busy=%b want 0/1", name, n, d, bz);
        end
      end else begin
        total++;
        if (d !== 1'b1 || bz !== 1'b0 || v !== 2'b11) begin
          bad++;
          $display("FAIL %s done edge %0d: done=%b busy=%b vec=%b want 1/0/11", name, n, d, bz, v);
        end
        total++;
        if (e !== 4'(exp_err) || p !== (exp_err == 0)) begin
          bad++;
          $display("FAIL %s result: err=%0d pass=%b want err=%0d pass=%b", name, e, p, exp_err, exp_err == 0);
        end
`ifdef GATE_CHECK_FAIL_LOG_EN
        total++;
        if (fv !== (exp_fi >= 0) || fvec !== ((exp_fi >= 0) ? 2'(exp_fi) : 2'b00) || fobs !== exp_fobs) begin
          bad++;
          $display("FAIL %s faillog: v=%b vec=%b obs=%h want v=%b vec=%0d obs=%h",
                   name, fv, fvec, fobs, exp_fi >= 0, (exp_fi >= 0) ? exp_fi : 0, exp_fobs);
        end
`endif
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s vec_count: left=%0d want 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_vals(input int sel, input string name);
    logic d, bz, p, fv;
    logic [3:0] e;
    logic [1:0] cv, v, fvec;
    logic [6:0] fobs;
    snap(sel, d, bz, p, e, cv, v, fv, fvec, fobs);
    total++;
    if ({d, bz, p, e, cv, v, fv, fvec, fobs} !== '0) begin
      bad++;
      $display("FAIL %s: done=%b busy=%b pass=%b err=%0d cur=%b vec=%b fv=%b fvec=%b fobs=%h want all 0",
               name, d, bz, p, e, cv, v, fv, fvec, fobs);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 4; i++) begin
      xm0[i] = 7'h00;
      xm1[i] = 7'h00;
    end
    clr0 = 7'h00;
    clr1 = 7'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    clear_faults();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(0, "reset_dut0");
    check_reset_vals(1, "reset_dut1");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(0, "idle_dut0");
  endtask

  task automatic test_good_sweep();
    clear_faults();
    run_sweep(0, 4, 1'b0, "good");
  endtask

  task automatic test_xor_stuck();
    clear_faults();
    clr0 = 7'h20;
    run_sweep(0, 4, 1'b0, "xor_stuck");
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      clear_faults();
      for (int i = 0; i < 4; i++)
        xm0[i] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'h00;
      if ($urandom_range(0, 3) == 0) clr0 = 7'($urandom_range(0, 127));
      run_sweep(0, 4, 1'b0, "random");
    end
  endtask

  task automatic test_saturate();
    clear_faults();
    clr1 = 7'h7F;
    run_sweep(1, 1, 1'b0, "saturate");
  endtask

  task automatic test_short_settle();
    clear_faults();
    run_sweep(1, 1, 1'b0, "short_settle");
  endtask

  task automatic test_start_held();
    int waited;
    clear_faults();
    clr0 = 7'h20;
    run_sweep(0, 4, 1'b1, "held");
    @(posedge clk);
    #1;
    total++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || err0 !== 4'd0 || pass0 !== 1'b0) begin
      bad++;
      $display("FAIL held_restart: done=%b busy=%b err=%0d pass=%b want 0/1/0/0", done0, busy0, err0, pass0);
    end
    start0 = 1'b0;
    waited = 0;
    while (done0 !== 1'b1 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    total++;
    if (done0 !== 1'b1 || waited != 24 || err0 !== 4'd2) begin
      bad++;
      $display("FAIL held_second: done=%b edges=%0d err=%0d want 1/24/2", done0, waited, err0);
    end
  endtask

  task automatic test_mid_reset();
    int seen_done;
    clear_faults();
    clr0 = 7'h20;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals(0, "mid_reset");
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done0 === 1'b1 || busy0 === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL mid_reset_quiet: active_cycles=%0d want 0", seen_done);
    end
    clr0 = 7'h00;
    run_sweep(0, 4, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_good_sweep();
    test_xor_stuck();
    test_random();
    test_saturate();
    test_short_settle();
    test_start_held();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
